// File: rtl/fp_round_pack.sv
// Single-precision multiplier back end: normalizes the 48-bit significand product,
// rounds to nearest-even and packs the IEEE-754 result. Two pipeline stages with a valid/ready handshake.
module fp_round_pack (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_fp1,
  input  logic [31:0] in_fp2,
  input  logic [47:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_overflow,
  output logic        out_underflow,
  output logic        out_invalid
);

  logic adv;

  // Stage 1 next-state (normalize + classify)
  logic              n1_sign, n1_guard, n1_sticky, n1_norm;
  logic [22:0]       n1_frac;
  logic signed [9:0] n1_exp;
  logic              n1_nan, n1_inf, n1_zero;

  // Stage 1 registers
  logic              s1_valid;
  logic              s1_sign, s1_guard, s1_sticky;
  logic [22:0]       s1_frac;
  logic signed [9:0] s1_exp;
  logic              s1_nan, s1_inf, s1_zero;

  // Stage 2 next-state (round + pack)
  logic              inc, carry;
  logic [22:0]       f2;
  logic signed [9:0] e2;
  logic [31:0]       n2_result;
  logic              n2_overflow, n2_underflow, n2_invalid;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  always_comb begin
    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    n1_sign   = in_fp1[31] ^ in_fp2[31];
    n1_norm   = in_mant[47];
    n1_frac   = in_mant[45:23];
    n1_guard  = in_mant[22];
    n1_sticky = |in_mant[21:0];
    if (in_mant[47]) begin
      n1_frac   = in_mant[46:24];
      n1_guard  = in_mant[23];
      n1_sticky = |in_mant[22:0];
    end
    ea = in_fp1[30:23];
    eb = in_fp2[30:23];
    n1_exp = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127
           + $signed({9'd0, n1_norm});
    // Denormal inputs are flushed: exponent 0 means zero regardless of fraction.
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    a_inf  = (ea == 8'hFF) && (in_fp1[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (in_fp2[22:0] == 23'd0);
    a_nan  = (ea == 8'hFF) && (in_fp1[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (in_fp2[22:0] != 23'd0);
    n1_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
    n1_inf  = a_inf || b_inf;
    n1_zero = a_zero || b_zero;
  end

  always_comb begin
    inc          = s1_guard & (s1_sticky | s1_frac[0]);
    {carry, f2}  = {1'b0, s1_frac} + {23'd0, inc};
    e2           = s1_exp + $signed({9'd0, carry});
    n2_result    = {s1_sign, e2[7:0], f2};
    n2_overflow  = 1'b0;
    n2_underflow = 1'b0;
    n2_invalid   = 1'b0;
    if (s1_nan) begin
      n2_result  = 32'h7FC0_0000;
      n2_invalid = 1'b1;
    end else if (s1_inf) begin
      n2_result = {s1_sign, 8'hFF, 23'd0};
    end else if (s1_zero) begin
      n2_result = {s1_sign, 31'd0};
    end else if (e2 >= 10'sd255) begin
      n2_result   = {s1_sign, 8'hFF, 23'd0};
      n2_overflow = 1'b1;
    end else if (e2 <= 10'sd0) begin
      n2_result    = {s1_sign, 31'd0};
      n2_underflow = 1'b1;
    end
  end

  // NOTE: stage-1 payload is qualified by s1_valid, so it carries no reset; only control/output state does.
  always_ff @(posedge clk) begin
    if (adv) begin
      s1_sign   <= n1_sign;
      s1_frac   <= n1_frac;
      s1_guard  <= n1_guard;
      s1_sticky <= n1_sticky;
      s1_exp    <= n1_exp;
      s1_nan    <= n1_nan;
      s1_inf    <= n1_inf;
      s1_zero   <= n1_zero;
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them sample pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      s1_valid      <= 1'b0;
      out_valid     <= 1'b0;
      out_result    <= 32'd0;
      out_overflow  <= 1'b0;
      out_underflow <= 1'b0;
      out_invalid   <= 1'b0;
    end else if (adv) begin
      s1_valid      <= in_valid;
      out_valid     <= s1_valid;
      out_result    <= n2_result;
      out_overflow  <= s1_valid && n2_overflow;
      out_underflow <= s1_valid && n2_underflow;
      out_invalid   <= s1_valid && n2_invalid;
    end
  end

endmodule
